// File: rtl/gamecfg_pkg.sv
//------------------------------------------------------------------------------
// Module   : gamecfg_pkg
// Brief    : Shared game-configuration types, state encoding and level table
//            for the difficulty scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gamecfg_pkg;

    localparam int c_SEL_W    = 2;
    localparam int c_TSEL_W   = 3;
    localparam int c_LEVEL_W  = 3;
    localparam int c_STREAK_W = 4;
    localparam int c_PAUSE_W  = 8;

    // Scheduler state encoding
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_APPLY = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_PAUSE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    typedef struct packed {
        logic [c_SEL_W-1:0]  select;
        logic [c_TSEL_W-1:0] timeselect;
    } level_cfg_t;

    localparam level_cfg_t c_LVL0_CFG  = '{select: 2'b00, timeselect: 3'b000};
    localparam level_cfg_t c_LVL1_CFG  = '{select: 2'b00, timeselect: 3'b001};
    localparam level_cfg_t c_LVL2_CFG  = '{select: 2'b01, timeselect: 3'b001};
    localparam level_cfg_t c_LVL3_CFG  = '{select: 2'b00, timeselect: 3'b010};
    localparam level_cfg_t c_LVL4_CFG  = '{select: 2'b01, timeselect: 3'b010};
    localparam level_cfg_t c_LVL5_CFG  = '{select: 2'b11, timeselect: 3'b001};
    localparam level_cfg_t c_LVL67_CFG = '{select: 2'b11, timeselect: 3'b010};

    function automatic level_cfg_t level_cfg(input logic [c_LEVEL_W-1:0] lvl);
        level_cfg_t cfg;
        case (lvl)
            3'd0:    cfg = c_LVL0_CFG;
            3'd1:    cfg = c_LVL1_CFG;
            3'd2:    cfg = c_LVL2_CFG;
            3'd3:    cfg = c_LVL3_CFG;
            3'd4:    cfg = c_LVL4_CFG;
            3'd5:    cfg = c_LVL5_CFG;
            default: cfg = c_LVL67_CFG;
        endcase
        return cfg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/difficulty_sched_if.sv
//------------------------------------------------------------------------------
// Module   : difficulty_sched_if
// Brief    : Game-FSM <-> difficulty scheduler handshake and status bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface difficulty_sched_if;
    import gamecfg_pkg::*;

    logic                  game_start;
    logic                  game_over;
    logic                  hit;
    logic                  miss;
    logic                  cfg_ack;
    logic                  cfg_valid;
    logic [c_SEL_W-1:0]    select;
    logic [c_TSEL_W-1:0]   timeselect;
    logic [c_LEVEL_W-1:0]  level;
    logic [c_STREAK_W-1:0] streak;
    logic                  level_up;

    // Game FSM side
    modport master (
        output game_start, game_over, hit, miss, cfg_ack,
        input  cfg_valid, select, timeselect, level, streak, level_up
    );

    // Scheduler side
    modport slave (
        input  game_start, game_over, hit, miss, cfg_ack,
        output cfg_valid, select, timeselect, level, streak, level_up
    );

endinterface

`default_nettype wire

// File: rtl/streak_counter.sv
//------------------------------------------------------------------------------
// Module   : streak_counter
// Brief    : Saturating consecutive-hit counter with clear and wrap detect.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module streak_counter
    import gamecfg_pkg::*;
#(
    parameter int LIMIT = 5
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  i_clr,
    input  wire logic                  i_inc,
    input  wire logic                  i_sat,
    output logic [c_STREAK_W-1:0]      o_count,
    output logic                       o_wrap
);

    localparam logic [c_STREAK_W-1:0] c_LAST = c_STREAK_W'(LIMIT - 1);

    logic [c_STREAK_W-1:0] r_count;
    logic                  w_at_last;

    assign w_at_last = (r_count == c_LAST);
    // A wrap only happens when saturation is off; it drives the level advance.
    assign o_wrap    = i_inc && w_at_last && !i_sat && !i_clr;
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            if (!w_at_last) begin
                r_count <= r_count + 1'b1;
            end else if (!i_sat) begin
                r_count <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/difficulty_sched.sv
//------------------------------------------------------------------------------
// Module   : difficulty_sched
// Brief    : Hit-streak driven difficulty level scheduler with config handshake.
//            Optional level-down on consecutive misses: DIFFICULTY_SCHED_LEVEL_DOWN_EN
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module difficulty_sched
    import gamecfg_pkg::*;
#(
    parameter int STREAK_LEN   = 5,
    parameter int MAX_LEVEL    = 6,
    parameter int PAUSE_CYCLES = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    difficulty_sched_if.slave  bus
);

    localparam logic [c_LEVEL_W-1:0] c_MAX_LVL    = c_LEVEL_W'(MAX_LEVEL);
    localparam logic [c_PAUSE_W-1:0] c_PAUSE_LAST = c_PAUSE_W'(PAUSE_CYCLES - 1);

    logic [2:0]             r_state;
    logic [c_LEVEL_W-1:0]   r_level;
    logic [c_PAUSE_W-1:0]   r_pause_cnt;
    logic                   r_level_up;

    logic                   w_active;
    logic                   w_in_run;
    logic                   w_start;
    logic                   w_run_hit;
    logic                   w_run_miss;
    logic                   w_sat;
    logic                   w_wrap;
    logic                   w_level_down;
    logic [c_STREAK_W-1:0]  w_streak;
    level_cfg_t             w_cfg;

    assign w_active   = (r_state == c_ST_APPLY) || (r_state == c_ST_RUN) ||
                        (r_state == c_ST_PAUSE);
    assign w_in_run   = (r_state == c_ST_RUN);
    assign w_start    = (r_state == c_ST_IDLE) && bus.game_start;
    // game_over outranks miss, and miss outranks hit
    assign w_run_miss = w_in_run && !bus.game_over && bus.miss;
    assign w_run_hit  = w_in_run && !bus.game_over && bus.hit && !bus.miss;
    assign w_sat      = (r_level == c_MAX_LVL);

    streak_counter #(
        .LIMIT (STREAK_LEN)
    ) u_streak (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_start || w_run_miss),
        .i_inc   (w_run_hit),
        .i_sat   (w_sat),
        .o_count (w_streak),
        .o_wrap  (w_wrap)
    );

`ifdef DIFFICULTY_SCHED_LEVEL_DOWN_EN
    logic r_miss_pend;

    assign w_level_down = w_run_miss && r_miss_pend && (r_level != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_miss_pend <= 1'b0;
        end else if (w_start || w_run_hit || w_level_down) begin
            r_miss_pend <= 1'b0;
        end else if (w_run_miss) begin
            r_miss_pend <= 1'b1;
        end
    end
`else
    assign w_level_down = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_level     <= '0;
            r_pause_cnt <= '0;
            r_level_up  <= 1'b0;
        end else begin
            r_level_up <= 1'b0;
            if (w_active && bus.game_over) begin
                r_state <= c_ST_DONE;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (bus.game_start) begin
                            r_state     <= c_ST_APPLY;
                            r_level     <= '0;
                            r_pause_cnt <= '0;
                        end
                    end
                    c_ST_APPLY: begin
                        if (bus.cfg_ack) begin
                            r_state <= c_ST_RUN;
                        end
                    end
                    c_ST_RUN: begin
                        if (w_level_down) begin
                            r_level     <= r_level - 1'b1;
                            r_pause_cnt <= '0;
                            r_state     <= c_ST_PAUSE;
                        end else if (w_wrap) begin
                            r_level     <= r_level + 1'b1;
                            r_level_up  <= 1'b1;
                            r_pause_cnt <= '0;
                            r_state     <= c_ST_PAUSE;
                        end
                    end
                    c_ST_PAUSE: begin
                        if (r_pause_cnt == c_PAUSE_LAST) begin
                            r_pause_cnt <= '0;
                            r_state     <= c_ST_APPLY;
                        end else begin
                            r_pause_cnt <= r_pause_cnt + 1'b1;
                        end
                    end
                    c_ST_DONE: begin
                        if (bus.game_start) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Level only changes outside APPLY, so the offered config is stable while valid.
    assign w_cfg          = level_cfg(r_level);
    assign bus.select     = w_cfg.select;
    assign bus.timeselect = w_cfg.timeselect;
    assign bus.cfg_valid  = (r_state == c_ST_APPLY);
    assign bus.level      = r_level;
    assign bus.streak     = w_streak;
    assign bus.level_up   = r_level_up;

endmodule

`default_nettype wire
